logic_issue_stage: RTL
======================

// Module: logic_issue_stage
// PURPOSE
//  Two-entry in-order issue buffer directly upstream of logic_unit.
//  Holds decoded logic ops until both operands are resolved, capturing
//  pending operands from the writeback broadcast bus by tag. Presents one
//  ready op per cycle (func_code, operands, dest tag) under valid/ready.
//  Decouples decode stalls from logic_unit operand availability.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width; matches logic_unit
//  TAG_WIDTH   5   physical register tag width
// PORTS
//  clk           in   1                    rising-edge clock
//  rst_n         in   1                    async active-low reset
//  flush         in   1                    sync squash of all held ops
//  in_valid      in   1                    upstream op valid
//  in_ready      out  1                    buffer can accept
//  in_func       in   LOGIC_OPCODE_WIDTH   OR/AND/XOR code
//  in_a, in_b    in   DATA_WIDTH           operand values (if not pending)
//  in_a_pend     in   1                    operand A awaits writeback
//  in_b_pend     in   1                    operand B awaits writeback
//  in_a_tag      in   TAG_WIDTH            producer tag for A
//  in_b_tag      in   TAG_WIDTH            producer tag for B
//  in_dst_tag    in   TAG_WIDTH            destination tag
//  wb_valid      in   1                    writeback broadcast valid
//  wb_tag        in   TAG_WIDTH            writeback tag
//  wb_data       in   DATA_WIDTH           writeback value
//  out_valid     out  1                    op ready for logic_unit
//  out_ready     in   1                    downstream accepts
//  out_func      out  LOGIC_OPCODE_WIDTH   to logic_unit func_code
//  out_a, out_b  out  DATA_WIDTH           to logic_unit data_in_a/b
//  out_dst_tag   out  TAG_WIDTH            dest tag, travels with result
//  occupancy     out  2                    held ops, 0..2
// BEHAVIOUR
//  - Async reset (rst_n=0): both entries invalid; occupancy=0, in_ready=1,
//    out_valid=0, out_func/out_a/out_b/out_dst_tag=0. No clock needed.
//  - Occupancy FSM: EMPTY -> ONE -> FULL. Push when in_valid&&in_ready;
//    pop when out_valid&&out_ready. Push+pop in ONE stays ONE.
//  - in_ready = (occupancy!=2). Never depends on out_ready (no comb path).
//  - Storage: 2 slots, 1-bit head/tail pointers, wrap 1->0. FIFO order is
//    strict; younger op never bypasses older even if its operands are ready.
//  - Wake-up: every cycle, each valid slot with pend_x=1 and
//    wb_valid&&wb_tag==tag_x loads data_x<=wb_data, clears pend_x. Same
//    compare applies to the incoming op on its push cycle (no missed wb).
//    A and B may match the same wb in one cycle; both capture.
//  - out_valid = head valid && !pend_a && !pend_b, from registers only.
//    Payload driven from head slot; stable while out_valid&&!out_ready.
//  - Latency: op pushed with no pending operand -> out_valid next cycle.
//    Wake-up at edge N -> out_valid after edge N.
//  - Invalid out_* (out_valid=0) are held at last value, not X.
//  - Unknown func codes pass through unchanged (logic_unit yields 0).
//  - flush: synchronous, priority over push/pop/wake-up; next cycle
//    occupancy=0, out_valid=0, in_ready=1. Input that cycle is dropped.
//  - Reset mid-op drops all held ops; no partial state survives.
// STRUCTURE
//  - LOGIC_OPCODE_WIDTH, OR/AND/XOR codes: shared logic_ops.svh.
//  - Add issue_slot_t struct (valid, func, a, b, pend_a/b, tags, dst) to
//    the shared header for reuse by the arith issue stage.
//  - Sub-module logic_issue_slot: one slot with load, wake-up compare,
//    clear; instantiated twice. Top holds pointers, FSM, muxes.
// TESTING
//  - Push AND, a=0xF0F0_F0F0, b=0xFF00_FF00, no pend, out_ready=1 -> next
//    cycle out_valid=1, out_a/out_b match, occupancy 1->0 on pop.
//  - Push XOR pend_a tag=3; wb tag=3 data=0x1234 two cycles later ->
//    out_valid one cycle after wb, out_a=0x1234.
//  - Push op with pend_a tag=7 same cycle as wb tag=7 data=0xAA -> captured,
//    out_valid next cycle with out_a=0xAA.
//  - out_ready=0, push 3 ops -> in_ready=0 after 2nd, occupancy=2, 3rd held
//    upstream; release out_ready -> ops exit in order, payload stable.
//  - Head pending, 2nd slot ready -> out_valid=0 (no reorder) until wb.
//  - FULL, assert flush with in_valid=1 -> next cycle occupancy=0,
//    out_valid=0, in_ready=1; rst_n low mid-stream -> immediate reset values.

Source files
------------

// File: rtl/logic_issue_pkg.sv
// Shared types for the logic issue stage: opcode codes, slot record, occupancy states.
package logic_issue_pkg;
  localparam int LOGIC_OPCODE_WIDTH = 2;
  localparam logic [LOGIC_OPCODE_WIDTH-1:0] LOGIC_OR  = 2'd0;
  localparam logic [LOGIC_OPCODE_WIDTH-1:0] LOGIC_AND = 2'd1;
  localparam logic [LOGIC_OPCODE_WIDTH-1:0] LOGIC_XOR = 2'd2;

  localparam int ISSUE_DW = 32;
  localparam int ISSUE_TW = 5;

  typedef struct packed {
    logic                          valid;
    logic [LOGIC_OPCODE_WIDTH-1:0] func;
    logic [ISSUE_DW-1:0]           a;
    logic [ISSUE_DW-1:0]           b;
    logic                          pend_a;
    logic                          pend_b;
    logic [ISSUE_TW-1:0]           tag_a;
    logic [ISSUE_TW-1:0]           tag_b;
    logic [ISSUE_TW-1:0]           dst;
  } issue_slot_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_t;

  // Both operands may match the same broadcast; each captures independently.
  function automatic issue_slot_t slot_wake(issue_slot_t s, logic wv,
                                            logic [ISSUE_TW-1:0] wt,
                                            logic [ISSUE_DW-1:0] wd);
    issue_slot_t r;
    r = s;
    if (wv && s.pend_a && (s.tag_a == wt)) begin
      r.a      = wd;
      r.pend_a = 1'b0;
    end
    if (wv && s.pend_b && (s.tag_b == wt)) begin
      r.b      = wd;
      r.pend_b = 1'b0;
    end
    return r;
  endfunction
endpackage

// File: rtl/logic_issue_slot.sv
// One issue-buffer entry: load with wake-up, per-cycle tag compare, clear on pop.
module logic_issue_slot
  import logic_issue_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                load,
  input  logic                clear,
  input  issue_slot_t         ld,
  input  logic                wb_valid,
  input  logic [ISSUE_TW-1:0] wb_tag,
  input  logic [ISSUE_DW-1:0] wb_data,
  output issue_slot_t         q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       q <= '0;
    else if (flush)   q <= '0;
    else if (load)    q <= slot_wake(ld, wb_valid, wb_tag, wb_data);
    else if (clear)   q.valid <= 1'b0;
    else if (q.valid) q <= slot_wake(q, wb_valid, wb_tag, wb_data);
  end
endmodule

// File: rtl/logic_issue_stage.sv
// Two-entry in-order issue buffer feeding logic_unit; operands captured from writeback by tag.
module logic_issue_stage
  import logic_issue_pkg::*;
#(
  parameter int DATA_WIDTH = ISSUE_DW,
  parameter int TAG_WIDTH  = ISSUE_TW
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LOGIC_OPCODE_WIDTH-1:0] in_func,
  input  logic [DATA_WIDTH-1:0]         in_a,
  input  logic [DATA_WIDTH-1:0]         in_b,
  input  logic                          in_a_pend,
  input  logic                          in_b_pend,
  input  logic [TAG_WIDTH-1:0]          in_a_tag,
  input  logic [TAG_WIDTH-1:0]          in_b_tag,
  input  logic [TAG_WIDTH-1:0]          in_dst_tag,
  input  logic                          wb_valid,
  input  logic [TAG_WIDTH-1:0]          wb_tag,
  input  logic [DATA_WIDTH-1:0]         wb_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LOGIC_OPCODE_WIDTH-1:0] out_func,
  output logic [DATA_WIDTH-1:0]         out_a,
  output logic [DATA_WIDTH-1:0]         out_b,
  output logic [TAG_WIDTH-1:0]          out_dst_tag,
  output logic [1:0]                    occupancy
);
  localparam int NUM_SLOTS = 2;

  occ_state_t  state;
  logic        head, tail;
  logic        push, pop;
  issue_slot_t in_slot, head_q;
  issue_slot_t slot_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_load, slot_clear;

  logic [LOGIC_OPCODE_WIDTH-1:0] held_func;
  logic [DATA_WIDTH-1:0]         held_a, held_b;
  logic [TAG_WIDTH-1:0]          held_dst;

  assign in_ready = (state != OCC_FULL);
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  always_comb begin
    in_slot        = '0;
    in_slot.valid  = 1'b1;
    in_slot.func   = in_func;
    in_slot.a      = in_a;
    in_slot.b      = in_b;
    in_slot.pend_a = in_a_pend;
    in_slot.pend_b = in_b_pend;
    in_slot.tag_a  = in_a_tag;
    in_slot.tag_b  = in_b_tag;
    in_slot.dst    = in_dst_tag;
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    assign slot_load[i]  = push && (tail == 1'(i));
    assign slot_clear[i] = pop  && (head == 1'(i));
    logic_issue_slot u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .load     (slot_load[i]),
      .clear    (slot_clear[i]),
      .ld       (in_slot),
      .wb_valid (wb_valid),
      .wb_tag   (wb_tag),
      .wb_data  (wb_data),
      .q        (slot_q[i])
    );
  end

  assign head_q    = slot_q[head];
  assign out_valid = head_q.valid && !head_q.pend_a && !head_q.pend_b;

  // Payload falls back to the last presented op whenever nothing is offered.
  assign out_func    = out_valid ? head_q.func : held_func;
  assign out_a       = out_valid ? head_q.a    : held_a;
  assign out_b       = out_valid ? head_q.b    : held_b;
  assign out_dst_tag = out_valid ? head_q.dst  : held_dst;
  assign occupancy   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_func <= '0;
      held_a    <= '0;
      held_b    <= '0;
      held_dst  <= '0;
    end else if (out_valid) begin
      held_func <= head_q.func;
      held_a    <= head_q.a;
      held_b    <= head_q.b;
      held_dst  <= head_q.dst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OCC_EMPTY;
      head  <= 1'b0;
      tail  <= 1'b0;
    end else if (flush) begin
      state <= OCC_EMPTY;
      head  <= 1'b0;
      tail  <= 1'b0;
    end else begin
      if (push) tail <= ~tail;
      if (pop)  head <= ~head;
      case (state)
        OCC_EMPTY: if (push) state <= OCC_ONE;
        OCC_ONE: begin
          if (push && !pop)      state <= OCC_FULL;
          else if (pop && !push) state <= OCC_EMPTY;
        end
        OCC_FULL:  if (pop) state <= OCC_ONE;
        default:   state <= OCC_EMPTY;
      endcase
    end
  end
endmodule
